// File: rtl/bist_controller_if.sv
// Handshake and data bundle between the test access logic, the BIST
// sequencer and the adder datapath's reset/enable/MISR connections.
interface bist_controller_if #(
    parameter int unsigned SIG_W = 17,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_patterns;
    logic [SIG_W-1:0] golden_sig;
    logic             misr_valid;
    logic [SIG_W-1:0] misr_sig;
    logic             bist_reset;
    logic             bist_enable;
    logic             busy;
    logic             done;
    logic             pass;
    logic             err;
    logic [SIG_W-1:0] sig_out;
    logic [CNT_W-1:0] pat_count;

    // Test access side plus datapath MISR feed
    modport master (
        output start, abort, num_patterns, golden_sig, misr_valid, misr_sig,
        input  bist_reset, bist_enable, busy, done, pass, err, sig_out, pat_count
    );

    // Sequencer side
    modport slave (
        input  start, abort, num_patterns, golden_sig, misr_valid, misr_sig,
        output bist_reset, bist_enable, busy, done, pass, err, sig_out, pat_count
    );
endinterface

// File: rtl/bist_controller.sv
// BIST session sequencer: clears the adder datapath, runs N enable cycles,
// drains the pipeline, captures the MISR signature and grades it.
// SIG_W/CNT_W must match the parameters of the connected interface.
module bist_controller #(
    parameter int unsigned SIG_W     = 17,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned CLR_CYC   = 2,
    parameter int unsigned FLUSH_CYC = 4
) (
    input logic               clk,
    input logic               reset,
    bist_controller_if.slave  bus
);
    localparam int unsigned PH_MAX = (CLR_CYC > FLUSH_CYC) ? CLR_CYC : FLUSH_CYC;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] CLR_LAST   = PH_W'(CLR_CYC - 1);
    localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, CLEAR, RUN, FLUSH, COMPARE, DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] n_lat;
    logic [PH_W-1:0]  phase;
    logic             seen_valid;

    // Session sequencer with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            n_lat           <= '0;
            phase           <= '0;
            seen_valid      <= 1'b0;
            bus.bist_reset  <= 1'b1;
            bus.bist_enable <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.pass        <= 1'b0;
            bus.err         <= 1'b0;
            bus.sig_out     <= '0;
            bus.pat_count   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.pat_count <= '0;
                        bus.sig_out   <= '0;
                        bus.pass      <= 1'b0;
                        seen_valid    <= 1'b0;
                        bus.busy      <= 1'b1;
                        if (bus.num_patterns != '0) begin
                            n_lat   <= bus.num_patterns;
                            phase   <= '0;
                            bus.err <= 1'b0;
                            state   <= CLEAR;
                        end else begin
                            bus.err  <= 1'b1;
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                CLEAR: begin
                    if (bus.abort) begin
                        bus.err  <= 1'b1;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else if (phase == CLR_LAST) begin
                        bus.bist_reset  <= 1'b0;
                        bus.bist_enable <= 1'b1;
                        state           <= RUN;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                RUN: begin
                    // The enable issued during this cycle is counted at its closing edge,
                    // including the cycle in which an abort is sampled.
                    if (bus.pat_count != n_lat)
                        bus.pat_count <= bus.pat_count + 1'b1;
                    if (bus.misr_valid)
                        seen_valid <= 1'b1;
                    if (bus.abort) begin
                        bus.bist_enable <= 1'b0;
                        bus.err         <= 1'b1;
                        bus.done        <= 1'b1;
                        state           <= DONE;
                    end else if (CNT_W'(bus.pat_count + 1'b1) == n_lat) begin
                        bus.bist_enable <= 1'b0;
                        phase           <= '0;
                        state           <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (bus.misr_valid)
                        seen_valid <= 1'b1;
                    if (bus.abort) begin
                        bus.err  <= 1'b1;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else if (phase == FLUSH_LAST) begin
                        state <= COMPARE;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                COMPARE: begin
                    bus.sig_out <= bus.misr_sig;
                    bus.pass    <= seen_valid && (bus.misr_sig == bus.golden_sig);
                    bus.err     <= !seen_valid;
                    bus.done    <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    bus.busy       <= 1'b0;
                    bus.bist_reset <= 1'b1;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bist_controller.sv
// Scoreboard bench for bist_controller with a behavioural datapath stub
// (pattern LFSR -> 3-stage pipe -> MISR) driven by bist_reset/bist_enable.
module tb_bist_controller;
    localparam int unsigned SIG_W = 17;
    localparam int unsigned CNT_W = 16;
    localparam logic [16:0] LFSR_INIT = 17'h1ACE1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic kill_valid = 1'b0;

    always #5 clk = ~clk;
    // cyc is the index of the current cycle; edge k closes cycle k
    always @(posedge clk) cyc <= cyc + 1;

    bist_controller_if #(.SIG_W(SIG_W), .CNT_W(CNT_W)) bus();

    bist_controller #(
        .SIG_W(SIG_W), .CNT_W(CNT_W), .CLR_CYC(2), .FLUSH_CYC(4)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    function automatic logic [16:0] lfsr_next(input logic [16:0] x);
        return {x[15:0], x[16] ^ x[13]};
    endfunction

    function automatic logic [16:0] misr_step(input logic [16:0] m, input logic [16:0] d);
        return {m[15:0], m[16] ^ m[13]} ^ d;
    endfunction

    function automatic logic [16:0] sig_model(input int n);
        logic [16:0] l = LFSR_INIT;
        logic [16:0] m = '0;
        for (int i = 0; i < n; i++) begin
            m = misr_step(m, l);
            l = lfsr_next(l);
        end
        return m;
    endfunction

    // Datapath stub
    logic [16:0] pat_lfsr, d0, d1, d2, misr;
    logic [2:0]  pipe;
    logic        mv;
    always @(posedge clk) begin
        if (bus.bist_reset) begin
            pat_lfsr <= LFSR_INIT;
            {d0, d1, d2} <= '0;
            pipe <= '0;
            misr <= '0;
            mv <= 1'b0;
        end else begin
            pipe <= {pipe[1:0], bus.bist_enable};
            d0 <= pat_lfsr;
            d1 <= d0;
            d2 <= d1;
            if (bus.bist_enable) pat_lfsr <= lfsr_next(pat_lfsr);
            if (pipe[2]) begin
                misr <= misr_step(misr, d2);
                mv <= 1'b1;
            end
        end
    end
    assign bus.misr_valid = mv && !kill_valid;
    assign bus.misr_sig   = misr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int          done_cyc;
        logic        pass;
        logic        err;
        logic [16:0] sig;
        logic [15:0] pat;
        int          n_en;
        int          first_en;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input int dc, input logic p, input logic e, input logic [16:0] s,
                            input logic [15:0] pc, input int ne, input int fe);
        exp_t x;
        x.done_cyc = dc; x.pass = p; x.err = e; x.sig = s; x.pat = pc;
        x.n_en = ne; x.first_en = fe;
        sb.push_back(x);
    endtask

    // Monitor: tracks enables and grades every done pulse against the queue
    int en_cnt = 0;
    int first_en = -1;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            en_cnt = 0;
            first_en = -1;
        end else begin
            if (bus.bist_enable) begin
                if (en_cnt == 0) first_en = cyc;
                en_cnt++;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    check("pass", 64'(bus.pass), 64'(e.pass));
                    check("err", 64'(bus.err), 64'(e.err));
                    check("sig_out", 64'(bus.sig_out), 64'(e.sig));
                    check("pat_count", 64'(bus.pat_count), 64'(e.pat));
                    check("enable_cycles", 64'(en_cnt), 64'(e.n_en));
                    check("first_enable", 64'(first_en), 64'(e.first_en));
                    en_cnt = 0;
                    first_en = -1;
                end
            end
        end
    end

    // Move to just after the edge that opens cycle c
    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_session(input logic [15:0] n, input logic [16:0] g, output int e0);
        @(posedge clk);
        #1;
        bus.num_patterns = n;
        bus.golden_sig = g;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e0 = cyc - 1;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({name, "_timeout"}, 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctrl"}, 64'({bus.bist_reset, bus.bist_enable, bus.busy,
                                     bus.done, bus.pass, bus.err}), 64'b100000);
        check({name, "_sig"}, 64'(bus.sig_out), 64'd0);
        check({name, "_pat"}, 64'(bus.pat_count), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.num_patterns = '0;
        bus.golden_sig = '0;

        // Reset held 3 cycles, then idle outputs must stay put
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_hold", 64'({bus.bist_reset, bus.bist_enable, bus.busy, bus.done,
                                   bus.pass, bus.err, bus.sig_out, bus.pat_count}),
                  64'({6'b100000, 17'd0, 16'd0}));
        end

        // Nominal run, N=8
        start_session(16'd8, sig_model(8), e0);
        push_exp(e0 + 16, 1'b1, 1'b0, sig_model(8), 16'd8, 8, e0 + 3);
        @(negedge clk);
        check("busy_rise", 64'(bus.busy), 64'd1);
        wait_drain("nominal");
        check("busy_fall", 64'(bus.busy), 64'd0);

        // Signature mismatch
        start_session(16'd8, sig_model(8) ^ 17'h00001, e0);
        push_exp(e0 + 16, 1'b0, 1'b0, sig_model(8), 16'd8, 8, e0 + 3);
        wait_drain("mismatch");

        // Zero patterns
        start_session(16'd0, 17'h0, e0);
        push_exp(e0 + 1, 1'b0, 1'b1, 17'h0, 16'd0, 0, -1);
        wait_drain("zero");

        // Abort after 3 enables, with an ignored start while running
        start_session(16'd100, 17'h0, e0);
        push_exp(e0 + 6, 1'b0, 1'b1, 17'h0, 16'd3, 3, e0 + 3);
        go_to(e0 + 4);
        bus.num_patterns = 16'd0;
        bus.start = 1'b1;
        go_to(e0 + 5);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        go_to(e0 + 6);
        bus.abort = 1'b0;
        wait_drain("abort");

        // No misr_valid ever seen
        kill_valid = 1'b1;
        start_session(16'd4, sig_model(4), e0);
        push_exp(e0 + 12, 1'b0, 1'b1, sig_model(4), 16'd4, 4, e0 + 3);
        wait_drain("no_valid");
        kill_valid = 1'b0;

        // Reset in FLUSH: back to reset values, no done pulse
        start_session(16'd8, sig_model(8), e0);
        go_to(e0 + 12);
        reset = 1'b1;
        go_to(e0 + 13);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        repeat (20) @(negedge clk);
        check("midrun_idle", 64'({bus.busy, bus.bist_enable}), 64'd0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
